// File: rtl/nonce_select.sv
// nonce_select: scans NUM_NONCES hash words from memory and reports the minimum hash and the first hash below target.
// Optional result write-back is enabled by defining NONCE_SELECT_WRITEBACK_EN.
module nonce_select #(
    parameter int NUM_NONCES = 16,
    parameter int NONCE_W    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [15:0]        hash_addr,
    input  logic [15:0]        result_addr,
    input  logic [31:0]        target,
    output logic               mem_clk,
    output logic               mem_we,
    output logic [15:0]        mem_addr,
    output logic [31:0]        mem_write_data,
    input  logic [31:0]        mem_read_data,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] best_nonce,
    output logic [31:0]        best_hash,
    output logic [NONCE_W-1:0] first_nonce
);

    // One spare index bit keeps the loop bound representable for power-of-two counts.
    localparam int IW = $clog2(NUM_NONCES) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NONCES - 1);
    localparam logic [IW-1:0] TWO      = IW'(2);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WB0, WB1, FIN} state_t;

    state_t        state;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] cmp_idx;
    logic          do_cmp;
    logic          new_best;
    logic          new_hit;

    assign mem_clk = clk;

    // Read data lags the registered address by two edges, so compares start once rd_idx reaches 2.
    assign do_cmp   = ((state == READ) && (rd_idx >= TWO)) || (state == DRAIN);
    assign new_best = mem_read_data < best_hash;
    assign new_hit  = (mem_read_data < target) && !found;

`ifndef NONCE_SELECT_WRITEBACK_EN
    logic unused_result_addr;
    assign unused_result_addr = ^result_addr;
    assign mem_we = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            rd_idx         <= '0;
            cmp_idx        <= '0;
`ifdef NONCE_SELECT_WRITEBACK_EN
            mem_we         <= 1'b0;
`endif
            mem_addr       <= 16'h0000;
            mem_write_data <= 32'h0000_0000;
            done           <= 1'b0;
            found          <= 1'b0;
            best_nonce     <= '0;
            best_hash      <= 32'h0000_0000;
            first_nonce    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr    <= hash_addr;
                        rd_idx      <= IW'(1);
                        cmp_idx     <= '0;
                        done        <= 1'b0;
                        found       <= 1'b0;
                        best_hash   <= 32'hFFFF_FFFF;
                        best_nonce  <= '0;
                        first_nonce <= '0;
                        state       <= READ;
                    end
                end
                READ: begin
                    mem_addr <= hash_addr + 16'(rd_idx);
                    rd_idx   <= rd_idx + IW'(1);
                    if (rd_idx == LAST_IDX) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cmp_idx == LAST_IDX) begin
`ifdef NONCE_SELECT_WRITEBACK_EN
                        state <= WB0;
`else
                        state <= FIN;
`endif
                    end
                end
`ifdef NONCE_SELECT_WRITEBACK_EN
                WB0: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= result_addr;
                    mem_write_data <= 32'(best_nonce);
                    state          <= WB1;
                end
                WB1: begin
                    mem_addr       <= result_addr + 16'h0001;
                    mem_write_data <= best_hash;
                    state          <= FIN;
                end
`endif
                FIN: begin
`ifdef NONCE_SELECT_WRITEBACK_EN
                    mem_we <= 1'b0;
`endif
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Strict less-than keeps the earliest nonce on ties.
            if (do_cmp) begin
                cmp_idx <= cmp_idx + IW'(1);
                if (new_best) begin
                    best_hash  <= mem_read_data;
                    best_nonce <= NONCE_W'(cmp_idx);
                end
                if (new_hit) begin
                    found       <= 1'b1;
                    first_nonce <= NONCE_W'(cmp_idx);
                end
            end
        end
    end

endmodule

// File: tb/tb_nonce_select.sv
// Directed bench for nonce_select with a memory model and a min/first-below-target reference model.
module tb_nonce_select;

    localparam int N  = 16;
    localparam int NW = 4;
`ifdef NONCE_SELECT_WRITEBACK_EN
    localparam int LAT = N + 4;
`else
    localparam int LAT = N + 2;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   hash_addr = 16'h0000;
    logic [15:0]   result_addr = 16'h0040;
    logic [31:0]   target = 32'h0;
    logic          mem_clk;
    logic          mem_we;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_write_data;
    logic [31:0]   mem_read_data;
    logic          done;
    logic          found;
    logic [NW-1:0] best_nonce;
    logic [31:0]   best_hash;
    logic [NW-1:0] first_nonce;

    nonce_select #(.NUM_NONCES(N), .NONCE_W(NW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .hash_addr(hash_addr), .result_addr(result_addr), .target(target),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .done(done), .found(found), .best_nonce(best_nonce),
        .best_hash(best_hash), .first_nonce(first_nonce)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:65535];
    logic [15:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    // Synchronous single-port memory.
    always @(posedge clk) begin
        mem_read_data <= mem[mem_addr];
        if (mem_we) begin
            mem[mem_addr] <= mem_write_data;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_write_data);
        end
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: minimum with lowest index, first index strictly below target.
    logic [31:0]   hv [N];
    bit            exp_valid = 1'b0;
    logic          exp_found;
    logic [NW-1:0] exp_best;
    logic [NW-1:0] exp_first;
    logic [31:0]   exp_hash;

    task automatic model();
        exp_hash  = hv[0];
        exp_best  = '0;
        exp_found = 1'b0;
        exp_first = '0;
        for (int i = 1; i < N; i++) begin
            if (hv[i] < exp_hash) begin
                exp_hash = hv[i];
                exp_best = NW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!exp_found && hv[i] < target) begin
                exp_found = 1'b1;
                exp_first = NW'(i);
            end
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid && done) begin
            chk("found", found, exp_found);
            chk("best_nonce", best_nonce, exp_best);
            chk("best_hash", best_hash, exp_hash);
            chk("first_nonce", first_nonce, exp_first);
            chk("mem_we_idle", mem_we, 1'b0);
        end
    end

    task automatic run_scan(input logic [15:0] ha, input logic [31:0] tg, input bit poke);
        int          n;
        bit          got;
        logic [15:0] a;
        exp_valid = 1'b0;
        hash_addr = ha;
        target    = tg;
        for (int i = 0; i < N; i++) begin
            a = ha + 16'(i);
            mem[a] = hv[i];
        end
        model();
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("addr0", mem_addr, ha);
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n < N) begin
                a = ha + 16'(n);
                chk("rd_addr", mem_addr, a);
            end
            if (n < LAT - 2) chk("we_scan", mem_we, 1'b0);
            if (poke && n == 5) start = 1'b1;
            if (poke && n == 6) start = 1'b0;
            if (done) got = 1'b1;
        end
        chk("latency", n, LAT);
`ifdef NONCE_SELECT_WRITEBACK_EN
        chk("wr_count", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            chk("wr0_addr", wr_addr_q[0], result_addr);
            chk("wr0_data", wr_data_q[0], 32'(exp_best));
            chk("wr1_addr", wr_addr_q[1], result_addr + 16'h0001);
            chk("wr1_data", wr_data_q[1], exp_hash);
        end
`else
        chk("wr_count", wr_addr_q.size(), 0);
`endif
        exp_valid = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_addr"}, mem_addr, 16'h0);
        chk({tag, "_wdata"}, mem_write_data, 32'h0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_found"}, found, 1'b0);
        chk({tag, "_best_nonce"}, best_nonce, '0);
        chk({tag, "_best_hash"}, best_hash, 32'h0);
        chk({tag, "_first"}, first_nonce, '0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        #23;
        chk_zero("rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mem_clk", mem_clk, 1'b0);

        // Descending hashes, nothing below a zero target.
        for (int i = 0; i < N; i++) hv[i] = 32'h1000 - 32'(i);
        run_scan(16'h0100, 32'h0, 1'b1);
        chk("desc_best_nonce", best_nonce, 4'd15);
        chk("desc_best_hash", best_hash, 32'h0000_0FF1);
        chk("desc_found", found, 1'b0);
        chk("desc_first", first_nonce, 4'd0);

        // Two qualifying words; first hit differs from minimum.
        for (int i = 0; i < N; i++) hv[i] = 32'hF000_0000;
        hv[5] = 32'h0000_0100;
        hv[9] = 32'h0000_0050;
        run_scan(16'h0100, 32'h0000_0200, 1'b0);
        chk("hit_found", found, 1'b1);
        chk("hit_first", first_nonce, 4'd5);
        chk("hit_best_nonce", best_nonce, 4'd9);
        chk("hit_best_hash", best_hash, 32'h0000_0050);

        // All-ones ties with an equal target, then uniform ties.
        for (int i = 0; i < N; i++) hv[i] = 32'hFFFF_FFFF;
        run_scan(16'h0200, 32'hFFFF_FFFF, 1'b0);
        chk("ones_best_nonce", best_nonce, 4'd0);
        chk("ones_best_hash", best_hash, 32'hFFFF_FFFF);
        chk("ones_found", found, 1'b0);
        for (int i = 0; i < N; i++) hv[i] = 32'h0000_1234;
        run_scan(16'h0200, 32'hFFFF_FFFF, 1'b0);
        chk("tie_best_nonce", best_nonce, 4'd0);
        chk("tie_best_hash", best_hash, 32'h0000_1234);

        // start held after done relaunches; done drops on the accepting edge.
        exp_valid = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("relaunch_done_drop", done, 1'b0);
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("relaunch_latency", n, LAT);
        exp_valid = 1'b1;
        @(negedge clk);

        // Address wrap past 0xFFFF.
        for (int i = 0; i < N; i++) hv[i] = $urandom;
        hv[11] = 32'h0000_0003;
        run_scan(16'hFFF8, 32'h4000_0000, 1'b0);

        // Reset asserted mid-scan clears everything asynchronously.
        exp_valid = 1'b0;
        wr_addr_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_wr_count", wr_addr_q.size(), 0);
        chk("midrst_idle_done", done, 1'b0);
        chk("midrst_idle_addr", mem_addr, 16'h0);

        // Recovery scan after reset.
        for (int i = 0; i < N; i++) hv[i] = 32'h8000_0000 + 32'(i * 7 % 13);
        run_scan(16'h0300, 32'h8000_0004, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
